// File: rtl/uparc_mem_stage.sv
// Memory-access stage of the Ultiparc pipeline: runs the data-bus transaction and aligns load data.
// Optional feature: define UPARC_MEM_BUS_TIMEOUT_EN to abort bus commands left unanswered for 255 cycles.
module uparc_mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_ld,
  input  logic        i_st,
  input  logic [1:0]  i_size,
  input  logic        i_sext,
  input  logic [31:0] i_alu_res,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_rd,
  output logic        o_valid,
  output logic [31:0] o_result,
  output logic [4:0]  o_rd,
  output logic        o_addr_err,
  output logic        o_bus_err,
  output logic [31:0] o_dbus_addr,
  output logic [1:0]  o_dbus_cmd,
  output logic [3:0]  o_dbus_be,
  output logic [31:0] o_dbus_wdata,
  input  logic        i_dbus_rdy,
  input  logic [31:0] i_dbus_rdata,
  input  logic        i_dbus_err
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUS = 2'd1, S_RESP = 2'd2} state_t;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  state_t      r_state;
  logic        r_ld;
  logic        r_sext;
  logic [1:0]  r_size;
  logic [1:0]  r_alo;
  logic [4:0]  r_rd;

  logic        w_mem;
  logic        w_misal;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_val;

  assign o_ready = (r_state == S_IDLE);
  assign w_mem   = i_ld | i_st;
  // size 11 behaves as a word, so bit 1 alone selects word alignment rules
  assign w_misal = i_size[1] ? (i_alu_res[1:0] != 2'b00) : (i_size[0] & i_alu_res[0]);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = i_wdata;
    case (i_size)
      2'b00: begin
        w_be    = 4'b0001 << i_alu_res[1:0];
        w_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << i_alu_res[1:0];
        w_wdata = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection works straight off the bus so the result is registered on the rdy edge.
  always_comb begin
    case (r_alo)
      2'd1:    w_byte = i_dbus_rdata[15:8];
      2'd2:    w_byte = i_dbus_rdata[23:16];
      2'd3:    w_byte = i_dbus_rdata[31:24];
      default: w_byte = i_dbus_rdata[7:0];
    endcase
    w_half = r_alo[1] ? i_dbus_rdata[31:16] : i_dbus_rdata[15:0];
    case (r_size)
      2'b00:   w_load_val = {{24{r_sext & w_byte[7]}}, w_byte};
      2'b01:   w_load_val = {{16{r_sext & w_half[15]}}, w_half};
      default: w_load_val = i_dbus_rdata;
    endcase
  end

`ifdef UPARC_MEM_BUS_TIMEOUT_EN
  logic [7:0] r_tmo;
  // r_tmo counts BUS cycles from 0; the 255th unanswered cycle ends the command
  assign w_timeout = (r_tmo == 8'd254);
  always_ff @(posedge clk) begin
    if (rst || r_state != S_BUS) r_tmo <= 8'd0;
    else                         r_tmo <= r_tmo + 8'd1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      o_valid      <= 1'b0;
      o_addr_err   <= 1'b0;
      o_bus_err    <= 1'b0;
      o_result     <= 32'd0;
      o_rd         <= 5'd0;
      o_dbus_cmd   <= CMD_IDLE;
      o_dbus_be    <= 4'd0;
      o_dbus_addr  <= 32'd0;
      o_dbus_wdata <= 32'd0;
      r_ld         <= 1'b0;
      r_sext       <= 1'b0;
      r_size       <= 2'd0;
      r_alo        <= 2'd0;
      r_rd         <= 5'd0;
    end else begin
      o_valid    <= 1'b0;
      o_addr_err <= 1'b0;
      o_bus_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            if (!w_mem) begin
              o_valid  <= 1'b1;
              o_result <= i_alu_res;
              o_rd     <= i_rd;
            end else if (w_misal) begin
              o_valid    <= 1'b1;
              o_addr_err <= 1'b1;
              o_result   <= 32'd0;
              o_rd       <= 5'd0;
            end else begin
              o_dbus_cmd   <= i_ld ? CMD_READ : CMD_WRITE;
              o_dbus_addr  <= {i_alu_res[31:2], 2'b00};
              o_dbus_be    <= w_be;
              o_dbus_wdata <= w_wdata;
              r_ld         <= i_ld;
              r_sext       <= i_sext;
              r_size       <= i_size;
              r_alo        <= i_alu_res[1:0];
              r_rd         <= i_rd;
              r_state      <= S_BUS;
            end
          end
        end
        S_BUS: begin
          if (i_dbus_rdy || w_timeout) begin
            o_dbus_cmd <= CMD_IDLE;
            o_dbus_be  <= 4'd0;
            o_valid    <= 1'b1;
            r_state    <= S_RESP;
            if (!i_dbus_rdy || i_dbus_err) begin
              o_bus_err <= 1'b1;
              o_result  <= 32'd0;
              o_rd      <= 5'd0;
            end else if (r_ld) begin
              o_result <= w_load_val;
              o_rd     <= r_rd;
            end else begin
              o_result <= 32'd0;
              o_rd     <= 5'd0;
            end
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uparc_mem_stage.sv
// Self-checking bench for uparc_mem_stage: directed vector table, corner sequences and random ops vs. a model.
module tb_uparc_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_ld, i_st, i_sext;
  logic [1:0]  i_size;
  logic [31:0] i_alu_res, i_wdata;
  logic [4:0]  i_rd;
  logic        o_ready, o_valid, o_addr_err, o_bus_err;
  logic [31:0] o_result, o_dbus_addr, o_dbus_wdata;
  logic [4:0]  o_rd;
  logic [1:0]  o_dbus_cmd;
  logic [3:0]  o_dbus_be;
  logic        i_dbus_rdy, i_dbus_err;
  logic [31:0] i_dbus_rdata;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        ld, st;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr, wdata;
    logic [4:0]  rd;
    int          waits;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] e_result;
    logic [4:0]  e_rd;
    logic        e_aerr, e_berr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
  } vec_t;

  uparc_mem_stage dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_ld(i_ld), .i_st(i_st), .i_size(i_size), .i_sext(i_sext),
    .i_alu_res(i_alu_res), .i_wdata(i_wdata), .i_rd(i_rd),
    .o_valid(o_valid), .o_result(o_result), .o_rd(o_rd),
    .o_addr_err(o_addr_err), .o_bus_err(o_bus_err),
    .o_dbus_addr(o_dbus_addr), .o_dbus_cmd(o_dbus_cmd), .o_dbus_be(o_dbus_be),
    .o_dbus_wdata(o_dbus_wdata), .i_dbus_rdy(i_dbus_rdy),
    .i_dbus_rdata(i_dbus_rdata), .i_dbus_err(i_dbus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkv(input logic ld, st, input logic [1:0] size, input logic sext,
                               input logic [31:0] addr, wdata, input logic [4:0] rd, input int waits,
                               input logic [31:0] rdata, input logic err, input logic [31:0] e_result,
                               input logic [4:0] e_rd, input logic e_aerr, e_berr,
                               input logic [3:0] e_be, input logic [31:0] e_wdata);
    vec_t v;
    v.ld = ld; v.st = st; v.size = size; v.sext = sext; v.addr = addr; v.wdata = wdata;
    v.rd = rd; v.waits = waits; v.rdata = rdata; v.err = err; v.e_result = e_result;
    v.e_rd = e_rd; v.e_aerr = e_aerr; v.e_berr = e_berr; v.e_be = e_be; v.e_wdata = e_wdata;
    return v;
  endfunction

  // Reference: byte-count arithmetic over lanes, not the DUT's case tables.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int n, a;
    logic [31:0] val, mask;
    n = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
    a = int'(v.addr[1:0]);
    r.e_be = '0; r.e_wdata = '0; r.e_aerr = 1'b0; r.e_berr = 1'b0;
    r.e_result = '0; r.e_rd = '0;
    if (!(v.ld || v.st)) begin
      r.e_result = v.addr;
      r.e_rd = v.rd;
      return r;
    end
    if ((a % n) != 0) begin
      r.e_aerr = 1'b1;
      return r;
    end
    for (int k = 0; k < 4; k++) begin
      if (k >= a && k < a + n) r.e_be[k] = 1'b1;
      r.e_wdata[8*k +: 8] = v.wdata[8*(k % n) +: 8];
    end
    if (v.err) r.e_berr = 1'b1;
    else if (v.ld) begin
      val = v.rdata >> (8 * a);
      if (n < 4) begin
        mask = (32'd1 << (8 * n)) - 32'd1;
        val = val & mask;
        if (v.sext && val[8*n-1]) val = val | ~mask;
      end
      r.e_result = val;
      r.e_rd = v.rd;
    end
    return r;
  endfunction

  task automatic run_op(input vec_t v, input string tag);
    logic mem;
    mem = (v.ld || v.st) && !v.e_aerr;
    chk({tag, ".ready_in"}, 32'(o_ready), 32'd1);
    i_valid = 1'b1; i_ld = v.ld; i_st = v.st; i_size = v.size; i_sext = v.sext;
    i_alu_res = v.addr; i_wdata = v.wdata; i_rd = v.rd;
    tick();
    i_valid = 1'b0; i_ld = 1'b0; i_st = 1'b0;
    i_alu_res = $urandom; i_wdata = $urandom;
    if (mem) begin
      for (int w = 0; w <= v.waits; w++) begin
        chk({tag, ".cmd"}, 32'(o_dbus_cmd), v.ld ? 32'd1 : 32'd2);
        chk({tag, ".addr"}, o_dbus_addr, {v.addr[31:2], 2'b00});
        chk({tag, ".be"}, 32'(o_dbus_be), 32'(v.e_be));
        if (v.st) chk({tag, ".wdata"}, o_dbus_wdata, v.e_wdata);
        chk({tag, ".valid_bus"}, 32'(o_valid), 32'd0);
        chk({tag, ".ready_bus"}, 32'(o_ready), 32'd0);
        if (w == v.waits) begin
          i_dbus_rdy = 1'b1; i_dbus_rdata = v.rdata; i_dbus_err = v.err;
        end else begin
          i_dbus_rdata = $urandom;
        end
        tick();
        i_dbus_rdy = 1'b0; i_dbus_err = 1'b0; i_dbus_rdata = $urandom;
      end
    end
    chk({tag, ".valid"}, 32'(o_valid), 32'd1);
    chk({tag, ".result"}, o_result, v.e_result);
    chk({tag, ".rd"}, 32'(o_rd), 32'(v.e_rd));
    chk({tag, ".aerr"}, 32'(o_addr_err), 32'(v.e_aerr));
    chk({tag, ".berr"}, 32'(o_bus_err), 32'(v.e_berr));
    chk({tag, ".cmd_done"}, 32'(o_dbus_cmd), 32'd0);
    $display("op %s ld=%0d st=%0d size=%0d addr=%h result=%h rd=%0d aerr=%0d berr=%0d",
             tag, v.ld, v.st, v.size, v.addr, o_result, o_rd, o_addr_err, o_bus_err);
    if (mem) begin
      chk({tag, ".ready_resp"}, 32'(o_ready), 32'd0);
      tick();
      chk({tag, ".valid_pulse"}, 32'(o_valid), 32'd0);
    end
  endtask

  vec_t tab[13];
  vec_t rv;

  initial begin
    tab[0]  = mkv(1,0,2'd0,1,32'h103,32'h0,5'd7,2,32'h80123456,0, 32'hFFFFFF80,5'd7,0,0,4'b1000,32'h0);
    tab[1]  = mkv(0,1,2'd1,0,32'h202,32'hAAAABEEF,5'd9,0,32'h0,0, 32'h0,5'd0,0,0,4'b1100,32'hBEEFBEEF);
    tab[2]  = mkv(1,0,2'd2,0,32'h106,32'h0,5'd3,0,32'h0,0, 32'h0,5'd0,1,0,4'b0000,32'h0);
    tab[3]  = mkv(1,0,2'd2,0,32'h40,32'h0,5'd4,1,32'h11111111,1, 32'h0,5'd0,0,1,4'b1111,32'h0);
    tab[4]  = mkv(1,0,2'd1,0,32'h102,32'h0,5'd6,0,32'h87654321,0, 32'h00008765,5'd6,0,0,4'b1100,32'h0);
    tab[5]  = mkv(1,0,2'd1,1,32'h102,32'h0,5'd6,1,32'h87654321,0, 32'hFFFF8765,5'd6,0,0,4'b1100,32'h0);
    tab[6]  = mkv(1,0,2'd0,0,32'h101,32'h0,5'd8,0,32'h123456F0,0, 32'h00000056,5'd8,0,0,4'b0010,32'h0);
    tab[7]  = mkv(0,1,2'd0,0,32'h3,32'h123456A5,5'd10,0,32'h0,0, 32'h0,5'd0,0,0,4'b1000,32'hA5A5A5A5);
    tab[8]  = mkv(0,1,2'd2,0,32'h10,32'hDEADBEEF,5'd11,3,32'h0,0, 32'h0,5'd0,0,0,4'b1111,32'hDEADBEEF);
    tab[9]  = mkv(1,0,2'd1,1,32'h201,32'h0,5'd12,0,32'h0,0, 32'h0,5'd0,1,0,4'b0000,32'h0);
    tab[10] = mkv(1,0,2'd3,1,32'h8,32'h0,5'd13,0,32'hCAFEF00D,0, 32'hCAFEF00D,5'd13,0,0,4'b1111,32'h0);
    tab[11] = mkv(0,0,2'd0,0,32'h12345678,32'h0,5'd5,0,32'h0,0, 32'h12345678,5'd5,0,0,4'b0000,32'h0);
    tab[12] = mkv(0,1,2'd0,0,32'h1,32'h77,5'd2,0,32'h0,1, 32'h0,5'd0,0,1,4'b0010,32'h77777777);

    rst = 1'b1; i_valid = 1'b0; i_ld = 1'b0; i_st = 1'b0; i_size = 2'd0; i_sext = 1'b0;
    i_alu_res = '0; i_wdata = '0; i_rd = '0;
    i_dbus_rdy = 1'b0; i_dbus_err = 1'b0; i_dbus_rdata = '0;
    tick(); tick();
    chk("rst.valid", 32'(o_valid), 32'd0);
    chk("rst.ready", 32'(o_ready), 32'd1);
    chk("rst.result", o_result, 32'd0);
    chk("rst.rd", 32'(o_rd), 32'd0);
    chk("rst.aerr", 32'(o_addr_err), 32'd0);
    chk("rst.berr", 32'(o_bus_err), 32'd0);
    chk("rst.cmd", 32'(o_dbus_cmd), 32'd0);
    chk("rst.be", 32'(o_dbus_be), 32'd0);
    chk("rst.addr", o_dbus_addr, 32'd0);
    chk("rst.wdata", o_dbus_wdata, 32'd0);
    rst = 1'b0;

    // Back-to-back pass-through ops: one result per cycle.
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1; i_alu_res = 32'h12345678; i_rd = 5'd5;
      tick();
      chk("b2b.valid", 32'(o_valid), 32'd1);
      chk("b2b.result", o_result, 32'h12345678);
      chk("b2b.rd", 32'(o_rd), 32'd5);
      chk("b2b.cmd", 32'(o_dbus_cmd), 32'd0);
      chk("b2b.ready", 32'(o_ready), 32'd1);
      $display("op b2b%0d result=%h rd=%0d", k, o_result, o_rd);
    end
    i_valid = 1'b0;
    tick();
    chk("b2b.valid_off", 32'(o_valid), 32'd0);

    for (int k = 0; k < 13; k++) run_op(tab[k], $sformatf("tab%0d", k));

    // Reset while a load waits on the bus, then a stray rdy while idle.
    i_valid = 1'b1; i_ld = 1'b1; i_size = 2'd2; i_alu_res = 32'h300; i_rd = 5'd1;
    tick();
    i_valid = 1'b0; i_ld = 1'b0;
    chk("mrst.cmd_before", 32'(o_dbus_cmd), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst.cmd", 32'(o_dbus_cmd), 32'd0);
    chk("mrst.ready", 32'(o_ready), 32'd1);
    chk("mrst.valid", 32'(o_valid), 32'd0);
    i_dbus_rdy = 1'b1; i_dbus_err = 1'b1; i_dbus_rdata = 32'hFFFFFFFF;
    tick();
    i_dbus_rdy = 1'b0; i_dbus_err = 1'b0;
    chk("late_rdy.valid", 32'(o_valid), 32'd0);
    chk("late_rdy.ready", 32'(o_ready), 32'd1);
    chk("late_rdy.berr", 32'(o_bus_err), 32'd0);
    $display("op mid_reset cmd=%0d ready=%0d", o_dbus_cmd, o_ready);

    // Unanswered command: aborted after 255 cycles when the timeout is built in.
    i_valid = 1'b1; i_ld = 1'b1; i_size = 2'd2; i_alu_res = 32'h400; i_rd = 5'd2;
    tick();
    i_valid = 1'b0; i_ld = 1'b0;
`ifdef UPARC_MEM_BUS_TIMEOUT_EN
    for (int k = 0; k < 255; k++) begin
      if (o_dbus_cmd !== 2'd1) begin
        chk("tmo.cmd_held", 32'(o_dbus_cmd), 32'd1);
        break;
      end
      tick();
    end
    chk("tmo.cmd_drop", 32'(o_dbus_cmd), 32'd0);
    chk("tmo.valid", 32'(o_valid), 32'd1);
    chk("tmo.berr", 32'(o_bus_err), 32'd1);
    chk("tmo.rd", 32'(o_rd), 32'd0);
    tick();
`else
    for (int k = 0; k < 300; k++) tick();
    chk("notmo.cmd_held", 32'(o_dbus_cmd), 32'd1);
    chk("notmo.valid", 32'(o_valid), 32'd0);
    i_dbus_rdy = 1'b1; i_dbus_rdata = 32'h0BADF00D;
    tick();
    i_dbus_rdy = 1'b0;
    chk("notmo.result", o_result, 32'h0BADF00D);
    chk("notmo.berr", 32'(o_bus_err), 32'd0);
    tick();
`endif
    $display("op long_wait berr=%0d", o_bus_err);

    for (int k = 0; k < 150; k++) begin
      int op;
      op = int'($urandom_range(0, 2));
      rv.ld = (op == 1); rv.st = (op == 2);
      rv.size = 2'($urandom_range(0, 3)); rv.sext = 1'($urandom_range(0, 1));
      rv.addr = $urandom; rv.wdata = $urandom; rv.rd = 5'($urandom_range(0, 31));
      rv.waits = int'($urandom_range(0, 3)); rv.rdata = $urandom;
      rv.err = ($urandom_range(0, 7) == 0);
      rv = model(rv);
      run_op(rv, $sformatf("rnd%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
